// File: rtl/rails_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : rails_pkg
//  Description : Shared constants, command encodings and sequencer states
//                for the railway-car stack sequencer.
//  Revision    : 1.0  initial release
// ============================================================================
package rails_pkg;

  // Longest train the sequencer will accept
  localparam int MAX_CARS = 10;
  // Width of car numbers, counts and indices
  localparam int CAR_W    = 4;

  // Command encodings presented on cmd_op (other codes are never driven)
  localparam logic [1:0] OP_PUSH = 2'b00;
  localparam logic [1:0] OP_POP  = 2'b01;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

endpackage
`default_nettype wire

// File: rtl/rails_lifo.sv
`default_nettype none
// ============================================================================
//  Module      : rails_lifo
//  Description : Synchronous shadow stack of DEPTH entries. Exposes the top
//                entry plus the one beneath it so the sequencer can look
//                ahead across a POP in the same cycle it is accepted.
//  Revision    : 1.0  initial release
// ============================================================================
module rails_lifo
  import rails_pkg::*;
#(
  parameter int DEPTH = MAX_CARS,
  parameter int W     = CAR_W
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clear,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] top,
  output logic [W-1:0] below,
  output logic         empty,
  output logic         single
);

  localparam int PW = $clog2(DEPTH + 1);
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] sp_q;
  logic [PW-1:0] sp_d;
  logic [PW-1:0] top_ptr;
  logic [PW-1:0] below_ptr;

  assign top_ptr   = sp_q - PW'(1);
  assign below_ptr = sp_q - PW'(2);
  assign empty     = (sp_q == '0);
  assign single    = (sp_q == PW'(1));
  assign top       = empty ? '0 : mem_q[top_ptr[IW-1:0]];
  assign below     = (sp_q < PW'(2)) ? '0 : mem_q[below_ptr[IW-1:0]];

  // Next stack pointer: clear wins, then push or pop (never both together)
  always_comb begin
    sp_d = sp_q;
    if (clear) begin
      sp_d = '0;
    end else if (push && !pop && (sp_q < PW'(DEPTH))) begin
      sp_d = sp_q + PW'(1);
    end else if (pop && !push && !empty) begin
      sp_d = sp_q - PW'(1);
    end
  end

  // Stack pointer register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sp_q <= '0;
    end else begin
      sp_q <= sp_d;
    end
  end

  // Entry storage; stale contents are never read because sp bounds all reads
  always_ff @(posedge clk) begin
    if (push && !pop && !clear && (sp_q < PW'(DEPTH))) begin
      mem_q[sp_q[IW-1:0]] <= din;
    end
  end

endmodule
`default_nettype wire

// File: rtl/rails_seq.sv
`default_nettype none
// ============================================================================
//  Module      : rails_seq
//  Description : Loads a target car order, then drives PUSH/POP commands to
//                the track datapath while a shadow stack decides whether the
//                order can be produced through a single siding.
//  Revision    : 1.0  initial release
// ============================================================================
module rails_seq
  import rails_pkg::*;
#(
  parameter int MAX_CARS = rails_pkg::MAX_CARS
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [CAR_W-1:0] in_data,
  output logic             cmd_valid,
  input  logic             cmd_ready,
  output logic [1:0]       cmd_op,
  output logic [CAR_W-1:0] cmd_car,
  output logic             done,
  output logic             result
);

  localparam logic [CAR_W-1:0] MAX_N = CAR_W'(MAX_CARS);

  state_e           state_q, state_d;
  logic [CAR_W-1:0] n_q, n_d;
  logic [CAR_W-1:0] idx_q, idx_d;
  logic [CAR_W-1:0] next_q, next_d;
  logic             cmd_valid_q, cmd_valid_d;
  logic [1:0]       cmd_op_q, cmd_op_d;
  logic [CAR_W-1:0] cmd_car_q, cmd_car_d;
  logic             result_q, result_d;

  logic [CAR_W-1:0] tgt_q [MAX_CARS];
  logic             tgt_we;

  logic             stk_clear, stk_push, stk_pop, stk_empty, stk_single;
  logic [CAR_W-1:0] stk_top, stk_below;

  logic             in_hs, cmd_hs;
  logic             eff_empty;
  logic [CAR_W-1:0] eff_idx, eff_next, eff_top, want;

  assign in_ready  = (state_q == ST_IDLE) || (state_q == ST_LOAD);
  assign in_hs     = in_valid && in_ready;
  assign cmd_hs    = cmd_valid_q && cmd_ready;
  assign stk_push  = cmd_hs && (cmd_op_q == OP_PUSH);
  assign stk_pop   = cmd_hs && (cmd_op_q == OP_POP);
  assign stk_clear = (state_q != ST_RUN);

  assign cmd_valid = cmd_valid_q;
  assign cmd_op    = cmd_op_q;
  assign cmd_car   = cmd_car_q;
  assign done      = (state_q == ST_DONE);
  assign result    = result_q;

  rails_lifo #(
    .DEPTH (MAX_CARS),
    .W     (CAR_W)
  ) u_lifo (
    .clk    (clk),
    .reset  (reset),
    .clear  (stk_clear),
    .push   (stk_push),
    .pop    (stk_pop),
    .din    (cmd_car_q),
    .top    (stk_top),
    .below  (stk_below),
    .empty  (stk_empty),
    .single (stk_single)
  );

  // Post-handshake view of stack and counters so the next command needs no bubble
  always_comb begin
    eff_idx   = idx_q;
    eff_next  = next_q;
    eff_top   = stk_top;
    eff_empty = stk_empty;
    if (stk_push) begin
      eff_next  = next_q + CAR_W'(1);
      eff_top   = cmd_car_q;
      eff_empty = 1'b0;
    end else if (stk_pop) begin
      eff_idx   = idx_q + CAR_W'(1);
      eff_top   = stk_below;
      eff_empty = stk_single;
    end
    want = tgt_q[eff_idx];
  end

  // Next-state, counter and command decision logic
  always_comb begin
    state_d     = state_q;
    n_d         = n_q;
    idx_d       = idx_q;
    next_d      = next_q;
    cmd_valid_d = cmd_valid_q;
    cmd_op_d    = cmd_op_q;
    cmd_car_d   = cmd_car_q;
    result_d    = result_q;
    tgt_we      = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (in_hs) begin
          n_d    = in_data;
          idx_d  = '0;
          next_d = CAR_W'(1);
          if (in_data == '0) begin
            state_d  = ST_DONE;
            result_d = 1'b1;
          end else if (in_data > MAX_N) begin
            state_d  = ST_DONE;
            result_d = 1'b0;
          end else begin
            state_d = ST_LOAD;
          end
        end
      end
      ST_LOAD: begin
        if (in_hs) begin
          tgt_we = 1'b1;
          idx_d  = idx_q + CAR_W'(1);
          if ((idx_q + CAR_W'(1)) == n_q) begin
            state_d = ST_RUN;
            idx_d   = '0;
            next_d  = CAR_W'(1);
          end
        end
      end
      ST_RUN: begin
        // A stalled command is held untouched until the datapath takes it
        if (!cmd_valid_q || cmd_ready) begin
          idx_d       = eff_idx;
          next_d      = eff_next;
          cmd_valid_d = 1'b0;
          if (eff_idx == n_q) begin
            state_d  = ST_DONE;
            result_d = 1'b1;
          end else if (!eff_empty && (eff_top == want)) begin
            cmd_valid_d = 1'b1;
            cmd_op_d    = OP_POP;
            cmd_car_d   = eff_top;
          end else if ((eff_next <= n_q) && (eff_next <= want)) begin
            cmd_valid_d = 1'b1;
            cmd_op_d    = OP_PUSH;
            cmd_car_d   = eff_next;
          end else begin
            state_d  = ST_DONE;
            result_d = 1'b0;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Control and command registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      n_q         <= '0;
      idx_q       <= '0;
      next_q      <= '0;
      cmd_valid_q <= 1'b0;
      cmd_op_q    <= OP_PUSH;
      cmd_car_q   <= '0;
      result_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      n_q         <= n_d;
      idx_q       <= idx_d;
      next_q      <= next_d;
      cmd_valid_q <= cmd_valid_d;
      cmd_op_q    <= cmd_op_d;
      cmd_car_q   <= cmd_car_d;
      result_q    <= result_d;
    end
  end

  // Target order storage, written in beat order while loading
  always_ff @(posedge clk) begin
    if (tgt_we) begin
      tgt_q[idx_q] <= in_data;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_rails_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rails_seq
//  Description : Table-driven self-checking bench for rails_seq, with
//                hand-written sequences for back-pressure and mid-run reset.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_rails_seq;

  localparam int NV   = 10;
  localparam int MAXC = 10;

  typedef struct {
    string name;
    int    n;
    string tgt;   // target order, one hex digit per car
    string cmds;  // expected commands: '+' PUSH / '-' POP followed by hex car
    bit    res;
  } vec_t;

  logic       clk = 1'b0;
  logic       reset;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] in_data;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_op;
  logic [3:0] cmd_car;
  logic       done;
  logic       result;

  int n_cmp  = 0;
  int n_fail = 0;

  vec_t vecs [NV];

  rails_seq dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_car   (cmd_car),
    .done      (done),
    .result    (result)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int hexv(input byte ch);
    if (ch >= 8'h61) return int'(ch) - 8'h61 + 10;
    return int'(ch) - 8'h30;
  endfunction

  task automatic send_beat(input logic [3:0] d);
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = d;
    chk("in_ready_load", in_ready, 1);
    @(posedge clk);
  endtask

  // Load a pattern, then follow the command stream to the done pulse.
  // stall_at/stall_len hold cmd_ready low on one command; abort_after stops
  // monitoring (without waiting for done) once that many commands transferred.
  task automatic run_vec(input vec_t t, input int stall_at, input int stall_len,
                         input int abort_after);
    int         ncmd;
    int         exp_n;
    int         stall_left;
    bit         got_done;
    logic [1:0] eop;
    logic [3:0] ecar;
    exp_n      = t.cmds.len() / 2;
    send_beat(4'(t.n));
    if (t.n >= 1 && t.n <= MAXC) begin
      for (int i = 0; i < t.n; i++) send_beat(4'(hexv(t.tgt[i])));
    end
    @(negedge clk);
    in_valid   = 1'b0;
    ncmd       = 0;
    got_done   = 1'b0;
    stall_left = stall_len;
    for (int cyc = 0; cyc < 300 && !got_done && (abort_after < 0 || ncmd < abort_after); cyc++) begin
      if (cyc > 0) @(negedge clk);
      cmd_ready = 1'b1;
      if (cmd_valid) begin
        if (ncmd >= exp_n) begin
          n_cmp++;
          n_fail++;
          $display("FAIL %s unexpected_cmd: got op %0d car %0d, expected none", t.name, cmd_op, cmd_car);
        end else begin
          eop  = (t.cmds[2*ncmd] == 8'h2d) ? 2'b01 : 2'b00;
          ecar = 4'(hexv(t.cmds[2*ncmd+1]));
          chk({t.name, "_cmd_op"}, cmd_op, eop);
          chk({t.name, "_cmd_car"}, cmd_car, ecar);
          if (ncmd == stall_at && stall_left > 0) begin
            cmd_ready = 1'b0;
            stall_left--;
          end
        end
        if (cmd_ready) ncmd++;
      end
      if (done) begin
        got_done = 1'b1;
        chk({t.name, "_cmd_count"}, ncmd, exp_n);
        chk({t.name, "_result"}, result, t.res);
        chk({t.name, "_done_in_ready"}, in_ready, 0);
        chk({t.name, "_done_cmd_valid"}, cmd_valid, 0);
      end
    end
    if (abort_after >= 0) return;
    if (!got_done) begin
      n_cmp++;
      n_fail++;
      $display("FAIL %s timeout: got no done, expected done within budget", t.name);
    end
    @(negedge clk);
    chk({t.name, "_post_done"}, done, 0);
    chk({t.name, "_post_in_ready"}, in_ready, 1);
    chk({t.name, "_post_result_held"}, result, t.res);
    chk({t.name, "_post_cmd_valid"}, cmd_valid, 0);
  endtask

  initial begin
    vecs[0] = '{"inorder5",   5,  "12345",      "+1-1+2-2+3-3+4-4+5-5", 1'b1};
    vecs[1] = '{"reject5",    5,  "54123",      "+1+2+3+4+5-5-4",       1'b0};
    vecs[2] = '{"reject3",    3,  "312",        "+1+2+3-3",             1'b0};
    vecs[3] = '{"accept3",    3,  "231",        "+1+2-2+3-3-1",         1'b1};
    vecs[4] = '{"empty",      0,  "",           "",                     1'b1};
    vecs[5] = '{"too_long",   11, "",           "",                     1'b0};
    vecs[6] = '{"zero_tgt",   3,  "102",        "+1-1",                 1'b0};
    vecs[7] = '{"big_tgt",    2,  "13",         "+1-1+2",               1'b0};
    vecs[8] = '{"full_rev",   10, "a987654321",
                "+1+2+3+4+5+6+7+8+9+a-a-9-8-7-6-5-4-3-2-1", 1'b1};
    vecs[9] = '{"single",     1,  "1",          "+1-1",                 1'b1};

    reset     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    cmd_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_cmd_valid", cmd_valid, 0);
    chk("rst_done", done, 0);
    chk("rst_result", result, 0);
    reset = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", in_ready, 1);

    for (int v = 0; v < NV; v++) run_vec(vecs[v], -1, 0, -1);

    // Back-pressure on the second command for four cycles
    run_vec(vecs[3], 1, 4, -1);

    // Reset while RUN has transferred three commands and a fourth is pending
    run_vec(vecs[0], -1, 0, 3);
    @(negedge clk);
    chk("pre_reset_cmd_valid", cmd_valid, 1);
    chk("pre_reset_result", result, 1);
    reset = 1'b0;
    #1;
    chk("mid_rst_cmd_valid", cmd_valid, 0);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_result", result, 0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("post_rst_in_ready", in_ready, 1);
    chk("post_rst_cmd_valid", cmd_valid, 0);
    run_vec(vecs[2], -1, 0, -1);
    run_vec(vecs[3], -1, 0, -1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/rails_seq.md
RAILS_SEQ -- requirements
Module: rails_seq

Interface
REQ-001 Parameter MAX_CARS, default 10, max train length; car numbers and counts 4 bits wide.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-004 in_valid  input  1  pattern beat valid.
REQ-005 in_ready  output  1  block accepts a pattern beat.
REQ-006 in_data  input  4  first beat = count N, next N beats = target order of cars.
REQ-007 cmd_valid  output  1  stack command valid to track datapath.
REQ-008 cmd_ready  input  1  datapath accepts command.
REQ-009 cmd_op  output  2  00 PUSH, 01 POP, others reserved and never driven.
REQ-010 cmd_car  output  4  car number pushed or popped.
REQ-011 done  output  1  one-cycle pulse, sequencing finished.
REQ-012 result  output  1  1 = order achievable; meaningful when done=1, held until next done.

Function
REQ-013 Beat transfer SHALL occur when in_valid&in_ready; command transfer when cmd_valid&cmd_ready.
REQ-014 States SHALL be IDLE, LOAD, RUN, DONE.
REQ-015 IDLE: in_ready=1; accepted beat stored as N; N=0 -> DONE result=1; N>MAX_CARS -> DONE result=0; else -> LOAD.
REQ-016 LOAD: in_ready=1; store N target beats in order; after Nth beat -> RUN with next=1, idx=0, shadow stack empty.
REQ-017 in_ready SHALL be 0 in RUN and DONE.
REQ-018 RUN decision, evaluated when no command outstanding: stack non-empty and top==target[idx] -> POP top, idx+1; else next<=N and next<=target[idx] -> PUSH next, next+1; else fail.
REQ-019 Target values 0 or >N SHALL lead to fail via REQ-018 without special-case logic.
REQ-020 cmd_valid, cmd_op, cmd_car SHALL be registered and held stable while cmd_valid=1 and cmd_ready=0.
REQ-021 First command SHALL appear the cycle after entering RUN; after a handshake, the next command SHALL appear the following cycle with no bubble.
REQ-022 Shadow stack and counters SHALL update only on handshake, never on presentation.
REQ-023 idx==N after final POP handshake -> DONE, result=1; fail -> DONE, result=0, no further commands.
REQ-024 DONE SHALL last exactly one cycle (done=1) then return to IDLE.
REQ-025 Stack depth SHALL never exceed N; no overflow path exists.

Reset
REQ-026 Reset SHALL force IDLE; in_ready=1 after release, cmd_valid=0, done=0, result=0, N, idx, next, stack pointer cleared.
REQ-027 Reset mid-LOAD or mid-RUN SHALL abandon the pattern; any outstanding command is dropped.
REQ-028 Target and stack storage need no reset; contents ignored until rewritten.

Structure
REQ-029 Shared package rails_pkg SHALL hold MAX_CARS, cmd_op encodings, state enumeration.
REQ-030 Shadow stack SHALL be sub-module rails_lifo (push, pop, top, empty, synchronous, MAX_CARS deep).

Verification
REQ-031 N=5, 1 2 3 4 5, cmd_ready=1 -> PUSH1 POP1 PUSH2 POP2 ... POP5 (10 cmds back-to-back), done result=1.
REQ-032 N=5, 5 4 1 2 3 -> PUSH1..PUSH5 POP5 POP4 (7 cmds), done result=0.
REQ-033 N=3, 3 1 2 -> PUSH1 PUSH2 PUSH3 POP3, done result=0; N=3, 2 3 1 -> 6 cmds, result=1.
REQ-034 cmd_ready low 4 cycles on second command -> cmd_op/cmd_car stable, sequence unchanged.
REQ-035 N=0 -> done result=1 no cmds; N=11 -> done result=0 no cmds, in_ready=1 next cycle.
REQ-036 reset low during RUN after 3 commands -> all outputs cleared; new pattern then runs correctly.
